// File: rtl/dm_arb_pkg.sv
// Shared definitions for the dm_arbiter slice: FSM encoding, requester ids and
// the default data-memory window.
package dm_arb_pkg;

    localparam int DM_ADDR_BITS = 10;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

    // Any address bit above the decoded window makes the access out of range.
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned abits);
        return (addr >> abits) != 32'd0;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signals of dm_arbiter. The slave modport is the
// arbiter's view; master is the view of the requesters plus the memory.
interface dm_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rdata;

    logic        mem_WrEn;
    logic [31:0] mem_Addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_WrEn, mem_Addr, mem_data_in,
        input  mem_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_WrEn, mem_Addr, mem_data_in,
        output mem_dout
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way selector: round-robin on ties, or fixed priority to
// requester 0 when prio_mode is set.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       prio_mode,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        if (req == 2'b10) begin
            gnt_id = REQ_DMA;
        end else if (req == 2'b11) begin
            gnt_id = prio_mode ? REQ_CPU : ~last_gnt;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester sequencer in front of the data memory; one word access per
// four cycles, absorbing the memory's registered read latency.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | sample requests, latch winner's command
//   ST_ACCESS | drive memory address/data, single-cycle write enable
//   ST_WAIT   | memory read data arrives, captured into rdata_q
//   ST_RESP   | one-cycle ack/err/rdata to the owner
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_BITS = DM_ADDR_BITS,
    parameter bit PRIO_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);

    state_t      state;
    logic        last_gnt;
    logic        owner;
    logic        cmd_we;
    logic        cmd_err;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] rdata_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        gnt_id;
    logic        gnt_valid;

    rr_arb2 u_sel (
        .req       ({bus.m1_req, bus.m0_req}),
        .last_gnt  (last_gnt),
        .prio_mode (PRIO_MODE),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_gnt   <= 1'b1;
            owner      <= REQ_CPU;
            cmd_we     <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        owner     <= gnt_id;
                        last_gnt  <= gnt_id;
                        cmd_we    <= gnt_id ? bus.m1_we    : bus.m0_we;
                        cmd_addr  <= gnt_id ? bus.m1_addr  : bus.m0_addr;
                        cmd_wdata <= gnt_id ? bus.m1_wdata : bus.m0_wdata;
                        cmd_err   <= addr_oob(gnt_id ? bus.m1_addr : bus.m0_addr, ADDR_BITS);
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: state <= ST_WAIT;
                ST_WAIT: begin
                    // For writes the memory forwards the new word, so this is the post-write value.
                    rdata_q <= cmd_err ? 32'd0 : bus.mem_dout;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner == REQ_DMA) m1_rdata_q <= rdata_q;
                    else                  m0_rdata_q <= rdata_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.m0_ack      = 1'b0;
        bus.m0_err      = 1'b0;
        bus.m1_ack      = 1'b0;
        bus.m1_err      = 1'b0;
        bus.mem_WrEn    = 1'b0;
        bus.mem_Addr    = '0;
        bus.mem_data_in = '0;
        case (state)
            ST_ACCESS: begin
                bus.mem_WrEn    = cmd_we & ~cmd_err;
                bus.mem_Addr    = cmd_addr;
                bus.mem_data_in = cmd_wdata;
            end
            ST_WAIT: begin
                bus.mem_Addr    = cmd_addr;
                bus.mem_data_in = cmd_wdata;
            end
            ST_RESP: begin
                if (owner == REQ_DMA) begin
                    bus.m1_ack = 1'b1;
                    bus.m1_err = cmd_err;
                end else begin
                    bus.m0_ack = 1'b1;
                    bus.m0_err = cmd_err;
                end
            end
            default: ;
        endcase
    end

    // Owner sees the fresh word during its ack; otherwise each port holds its last result.
    assign bus.m0_rdata = (state == ST_RESP && owner == REQ_CPU) ? rdata_q : m0_rdata_q;
    assign bus.m1_rdata = (state == ST_RESP && owner == REQ_DMA) ? rdata_q : m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed requests push expected acks into
// per-instance queues; monitors pop and compare whenever an ack appears.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    exp_t sb_rr[$];
    exp_t sb_fp[$];

    logic [31:0] mem_rr [256];
    logic [31:0] mem_fp [256];

    int          wr_cnt  = 0;
    int          wr_cyc  = -1;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    dm_arbiter_if bus_rr ();
    dm_arbiter_if bus_fp ();

    dm_arbiter #(.ADDR_BITS(10), .PRIO_MODE(1'b0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    dm_arbiter #(.ADDR_BITS(10), .PRIO_MODE(1'b1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memories with registered, write-first read port.
    always @(posedge clk) begin
        if (bus_rr.mem_WrEn) mem_rr[bus_rr.mem_Addr[9:2]] <= bus_rr.mem_data_in;
        bus_rr.mem_dout <= bus_rr.mem_WrEn ? bus_rr.mem_data_in : mem_rr[bus_rr.mem_Addr[9:2]];
        if (bus_fp.mem_WrEn) mem_fp[bus_fp.mem_Addr[9:2]] <= bus_fp.mem_data_in;
        bus_fp.mem_dout <= bus_fp.mem_WrEn ? bus_fp.mem_data_in : mem_fp[bus_fp.mem_Addr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (bus_rr.mem_WrEn) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_addr = bus_rr.mem_Addr;
            wr_data = bus_rr.mem_data_in;
        end
    end

    always @(negedge clk) begin
        if (bus_rr.m0_ack || bus_rr.m1_ack) begin
            exp_t e;
            logic id;
            chk("rr_dual_ack", {31'd0, bus_rr.m0_ack & bus_rr.m1_ack}, 32'd0);
            if (sb_rr.size() == 0) begin
                total++;
                $display("FAIL rr_unexpected_ack: ack seen at cycle %0d, required none", cyc);
            end else begin
                e  = sb_rr.pop_front();
                id = bus_rr.m1_ack;
                chk("rr_ack_id", {31'd0, id}, {31'd0, e.id});
                chk("rr_ack_err", {31'd0, id ? bus_rr.m1_err : bus_rr.m0_err}, {31'd0, e.err});
                chk("rr_ack_rdata", id ? bus_rr.m1_rdata : bus_rr.m0_rdata, e.rdata);
                chk("rr_ack_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_fp.m0_ack || bus_fp.m1_ack) begin
            exp_t e;
            logic id;
            chk("fp_dual_ack", {31'd0, bus_fp.m0_ack & bus_fp.m1_ack}, 32'd0);
            if (sb_fp.size() == 0) begin
                total++;
                $display("FAIL fp_unexpected_ack: ack seen at cycle %0d, required none", cyc);
            end else begin
                e  = sb_fp.pop_front();
                id = bus_fp.m1_ack;
                chk("fp_ack_id", {31'd0, id}, {31'd0, e.id});
                chk("fp_ack_err", {31'd0, id ? bus_fp.m1_err : bus_fp.m0_err}, {31'd0, e.err});
                chk("fp_ack_rdata", id ? bus_fp.m1_rdata : bus_fp.m0_rdata, e.rdata);
                chk("fp_ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (id) begin
            bus_rr.m1_we = we; bus_rr.m1_addr = addr; bus_rr.m1_wdata = wdata; bus_rr.m1_req = 1'b1;
        end else begin
            bus_rr.m0_we = we; bus_rr.m0_addr = addr; bus_rr.m0_wdata = wdata; bus_rr.m0_req = 1'b1;
        end
    endtask

    task automatic issue(input logic id, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_cyc);
        drive(id, we, addr, wdata);
        sb_rr.push_back('{id: id, err: exp_err, rdata: exp_rdata, cyc: exp_cyc});
    endtask

    task automatic wait_ack_drop(input logic id);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = id ? bus_rr.m1_ack : bus_rr.m0_ack;
        end
        if (!seen) begin
            total++;
            $display("FAIL ack_timeout_m%0d: no ack within 40 cycles, required an ack", id);
        end
        step();
        if (id) bus_rr.m1_req = 1'b0;
        else    bus_rr.m0_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int w0;
        for (int i = 0; i < 256; i++) begin
            mem_rr[i] = '0;
            mem_fp[i] = '0;
        end
        mem_fp[1] = 32'hA5A5_0001;
        mem_fp[2] = 32'h5A5A_0002;
        {bus_rr.m0_req, bus_rr.m0_we, bus_rr.m0_addr, bus_rr.m0_wdata} = '0;
        {bus_rr.m1_req, bus_rr.m1_we, bus_rr.m1_addr, bus_rr.m1_wdata} = '0;
        {bus_fp.m0_req, bus_fp.m0_we, bus_fp.m0_addr, bus_fp.m0_wdata} = '0;
        {bus_fp.m1_req, bus_fp.m1_we, bus_fp.m1_addr, bus_fp.m1_wdata} = '0;

        step(); step();
        @(negedge clk);
        chk("rst_m0_ack", {31'd0, bus_rr.m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'd0, bus_rr.m1_ack}, 32'd0);
        chk("rst_wren", {31'd0, bus_rr.mem_WrEn}, 32'd0);
        chk("rst_mem_addr", bus_rr.mem_Addr, 32'd0);
        chk("rst_m0_rdata", bus_rr.m0_rdata, 32'd0);
        chk("rst_m1_rdata", bus_rr.m1_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: write then read back through m0
        c  = cyc;
        w0 = wr_cnt;
        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, c + 3);
        wait_ack_drop(1'b0);
        chk("t1_wr_count", wr_cnt - w0, 32'd1);
        chk("t1_wr_cycle", wr_cyc, c + 1);
        chk("t1_wr_addr", wr_addr, 32'h10);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        step();
        c = cyc;
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, c + 3);
        wait_ack_drop(1'b0);

        // 4: out-of-range m1 read
        step();
        c  = cyc;
        w0 = wr_cnt;
        issue(1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b1, 32'h0, c + 3);
        wait_ack_drop(1'b1);
        chk("t4_no_write", wr_cnt - w0, 32'd0);
        chk("t4_m0_rdata_held", bus_rr.m0_rdata, 32'hDEADBEEF);

        // 5: reset during WAIT of an m0 write, then re-issue
        step();
        c = cyc;
        drive(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
        step();
        step();
        rst = 1'b1;
        bus_rr.m0_req = 1'b0;
        step();
        @(negedge clk);
        chk("t5_state", {30'd0, dut_rr.state}, {30'd0, ST_IDLE});
        chk("t5_m0_ack", {31'd0, bus_rr.m0_ack}, 32'd0);
        chk("t5_wren", {31'd0, bus_rr.mem_WrEn}, 32'd0);
        chk("t5_m0_rdata", bus_rr.m0_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();
        c = cyc;
        issue(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, c + 3);
        wait_ack_drop(1'b0);

        // 6: m0 read queued behind an in-flight m1 write to the same word
        step();
        c = cyc;
        issue(1'b1, 1'b1, 32'h20, 32'h11223344, 1'b0, 32'h11223344, c + 3);
        step();
        issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11223344, c + 7);
        fork
            wait_ack_drop(1'b1);
            wait_ack_drop(1'b0);
        join
        chk("t6_m1_rdata_held", bus_rr.m1_rdata, 32'h11223344);
        chk("t6_m0_rdata", bus_rr.m0_rdata, 32'h11223344);

        // 2: continuous contention, round-robin (reset so m0 wins the first tie)
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        c = cyc;
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        sb_rr.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF, cyc: c + 3});
        sb_rr.push_back('{id: 1'b1, err: 1'b0, rdata: 32'h11223344, cyc: c + 7});
        sb_rr.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF, cyc: c + 11});
        sb_rr.push_back('{id: 1'b1, err: 1'b0, rdata: 32'h11223344, cyc: c + 15});
        while (cyc < c + 12) step();
        bus_rr.m0_req = 1'b0;
        while (cyc < c + 16) step();
        bus_rr.m1_req = 1'b0;
        repeat (6) step();

        // 3: continuous contention, fixed priority
        c = cyc;
        bus_fp.m0_we = 1'b0; bus_fp.m0_addr = 32'h4; bus_fp.m0_req = 1'b1;
        bus_fp.m1_we = 1'b0; bus_fp.m1_addr = 32'h8; bus_fp.m1_req = 1'b1;
        sb_fp.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hA5A5_0001, cyc: c + 3});
        sb_fp.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hA5A5_0001, cyc: c + 7});
        sb_fp.push_back('{id: 1'b0, err: 1'b0, rdata: 32'hA5A5_0001, cyc: c + 11});
        sb_fp.push_back('{id: 1'b1, err: 1'b0, rdata: 32'h5A5A_0002, cyc: c + 15});
        while (cyc < c + 12) step();
        bus_fp.m0_req = 1'b0;
        while (cyc < c + 16) step();
        bus_fp.m1_req = 1'b0;
        repeat (6) step();

        chk("rr_sb_drained", sb_rr.size(), 32'd0);
        chk("fp_sb_drained", sb_fp.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
